// File: rtl/ysyx_24100012_idu.sv
// RV32I instruction decode stage with optional RV32M and Zicsr legality.
// One register slice between IFU and EXU with a valid/ready handshake on each side.
`timescale 1ns/1ps
module ysyx_24100012_idu #(
    parameter int DATA_WIDTH = 32,
    parameter int EN_M       = 0,
    parameter int EN_CSR     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_inst,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] imm,
    output logic [2:0]            func3,
    output logic [4:0]            ALUSel,
    output logic [1:0]            PCType,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [4:0]            rd,
    output logic                  ASel,
    output logic                  BSel,
    output logic                  WEn,
    output logic                  MemWEn,
    output logic                  MemREn,
    output logic                  csr_en,
    output logic                  is_ecall,
    output logic                  is_ebreak,
    output logic                  illegal,
    output logic [1:0]            WBSel,
    output logic [31:0]           dec_count
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] imm;
        logic [2:0]            func3;
        logic [4:0]            alu_sel;
        logic [1:0]            pc_type;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic                  a_sel;
        logic                  b_sel;
        logic                  wen;
        logic                  mem_wen;
        logic                  mem_ren;
        logic                  csr_en;
        logic                  is_ecall;
        logic                  is_ebreak;
        logic                  illegal;
        logic [1:0]            wb_sel;
    } bundle_t;

    bundle_t     bundle_next;
    bundle_t     bundle_reg;
    logic        out_valid_reg;
    logic [31:0] dec_count_reg;
    logic [31:0] imm32;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh, imm_z;
    logic        in_hs;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];

    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_sh = {27'b0, in_inst[24:20]};
    assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign imm_u  = {in_inst[31:12], 12'b0};
    assign imm_z  = {27'b0, in_inst[19:15]};

    assign in_ready = !out_valid_reg || out_ready;
    assign in_hs    = in_valid && in_ready;

    always_comb begin
        bundle_next        = '0;
        imm32              = '0;
        bundle_next.pc     = in_pc;
        bundle_next.func3  = f3;
        bundle_next.wb_sel = 2'b11;
        case (opcode)
            7'b0110011: begin
                bundle_next.rs1     = in_inst[19:15];
                bundle_next.rs2     = in_inst[24:20];
                bundle_next.rd      = in_inst[11:7];
                bundle_next.wen     = 1'b1;
                bundle_next.wb_sel  = 2'b00;
                bundle_next.alu_sel = {1'b0, in_inst[30], f3};
                if (f7 == 7'b0000000) begin
                    bundle_next.illegal = 1'b0;
                end else if (f7 == 7'b0100000) begin
                    bundle_next.illegal = !(f3 == 3'b000 || f3 == 3'b101);
                end else if (f7 == 7'b0000001 && EN_M != 0) begin
                    bundle_next.alu_sel = {2'b10, f3};
                end else begin
                    bundle_next.illegal = 1'b1;
                end
            end
            7'b0010011: begin
                bundle_next.rs1    = in_inst[19:15];
                bundle_next.rd     = in_inst[11:7];
                bundle_next.b_sel  = 1'b1;
                bundle_next.wen    = 1'b1;
                bundle_next.wb_sel = 2'b00;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    imm32               = imm_sh;
                    bundle_next.alu_sel = {1'b0, in_inst[30], f3};
                    bundle_next.illegal = (f3 == 3'b001) ? (f7 != 7'b0000000)
                                        : !(f7 == 7'b0000000 || f7 == 7'b0100000);
                end else begin
                    imm32               = imm_i;
                    bundle_next.alu_sel = {2'b00, f3};
                end
            end
            7'b0000011: begin
                imm32               = imm_i;
                bundle_next.rs1     = in_inst[19:15];
                bundle_next.rd      = in_inst[11:7];
                bundle_next.b_sel   = 1'b1;
                bundle_next.wen     = 1'b1;
                bundle_next.mem_ren = 1'b1;
                bundle_next.wb_sel  = 2'b10;
            end
            7'b0100011: begin
                imm32               = imm_s;
                bundle_next.rs1     = in_inst[19:15];
                bundle_next.rs2     = in_inst[24:20];
                bundle_next.b_sel   = 1'b1;
                bundle_next.mem_wen = 1'b1;
            end
            7'b1100011: begin
                imm32               = imm_b;
                bundle_next.rs1     = in_inst[19:15];
                bundle_next.rs2     = in_inst[24:20];
                bundle_next.a_sel   = 1'b1;
                bundle_next.b_sel   = 1'b1;
                bundle_next.pc_type = 2'b10;
            end
            7'b1101111: begin
                imm32               = imm_j;
                bundle_next.rd      = in_inst[11:7];
                bundle_next.a_sel   = 1'b1;
                bundle_next.b_sel   = 1'b1;
                bundle_next.wen     = 1'b1;
                bundle_next.wb_sel  = 2'b01;
                bundle_next.pc_type = 2'b01;
            end
            7'b1100111: begin
                imm32               = imm_i;
                bundle_next.rs1     = in_inst[19:15];
                bundle_next.rd      = in_inst[11:7];
                bundle_next.b_sel   = 1'b1;
                bundle_next.wen     = 1'b1;
                bundle_next.wb_sel  = 2'b01;
                bundle_next.pc_type = 2'b01;
            end
            7'b0010111, 7'b0110111: begin
                imm32              = imm_u;
                bundle_next.rd     = in_inst[11:7];
                bundle_next.a_sel  = (opcode == 7'b0010111);
                bundle_next.b_sel  = 1'b1;
                bundle_next.wen    = 1'b1;
                bundle_next.wb_sel = 2'b00;
            end
            7'b1110011: begin
                // ecall/ebreak are only legal with every other field zero
                if (f3 == 3'b000) begin
                    if (in_inst[31:7] == 25'd0) begin
                        bundle_next.is_ecall = 1'b1;
                    end else if (in_inst[31:7] == {12'd1, 13'd0}) begin
                        bundle_next.is_ebreak = 1'b1;
                    end else begin
                        bundle_next.illegal = 1'b1;
                    end
                end else if (EN_CSR != 0 && f3 != 3'b100) begin
                    bundle_next.csr_en = 1'b1;
                    bundle_next.wen    = 1'b1;
                    bundle_next.rd     = in_inst[11:7];
                    if (f3[2]) begin
                        imm32 = imm_z;
                    end else begin
                        imm32           = imm_i;
                        bundle_next.rs1 = in_inst[19:15];
                    end
                end else begin
                    bundle_next.illegal = 1'b1;
                end
            end
            default: bundle_next.illegal = 1'b1;
        endcase
        bundle_next.imm = DATA_WIDTH'($signed(imm32));
        if (bundle_next.illegal) begin
            bundle_next.wen       = 1'b0;
            bundle_next.mem_wen   = 1'b0;
            bundle_next.mem_ren   = 1'b0;
            bundle_next.csr_en    = 1'b0;
            bundle_next.is_ecall  = 1'b0;
            bundle_next.is_ebreak = 1'b0;
            bundle_next.pc_type   = 2'b00;
        end
    end

    // flush discards both the held bundle and any same-cycle input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            dec_count_reg <= '0;
            bundle_reg    <= '0;
        end else begin
            if (flush) begin
                out_valid_reg <= 1'b0;
            end else if (in_hs) begin
                out_valid_reg <= 1'b1;
                bundle_reg    <= bundle_next;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (out_valid_reg && out_ready && !flush) begin
                dec_count_reg <= dec_count_reg + 32'd1;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign dec_count = dec_count_reg;
    assign out_pc    = bundle_reg.pc;
    assign imm       = bundle_reg.imm;
    assign func3     = bundle_reg.func3;
    assign ALUSel    = bundle_reg.alu_sel;
    assign PCType    = bundle_reg.pc_type;
    assign rs1       = bundle_reg.rs1;
    assign rs2       = bundle_reg.rs2;
    assign rd        = bundle_reg.rd;
    assign ASel      = bundle_reg.a_sel;
    assign BSel      = bundle_reg.b_sel;
    assign WEn       = bundle_reg.wen;
    assign MemWEn    = bundle_reg.mem_wen;
    assign MemREn    = bundle_reg.mem_ren;
    assign csr_en    = bundle_reg.csr_en;
    assign is_ecall  = bundle_reg.is_ecall;
    assign is_ebreak = bundle_reg.is_ebreak;
    assign illegal   = bundle_reg.illegal;
    assign WBSel     = bundle_reg.wb_sel;
endmodule
